// File: rtl/fip_pkg.sv
// fip_pkg: shared divider state type and two's-complement saturation limits
package fip_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    function automatic logic [63:0] fip_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
    function automatic logic [63:0] fip_min(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/fip_div_seq.sv
// fip_div_seq: radix-2 restoring signed fixed-point divider; valid/ready operands in, quotient with overflow/div-zero flags out
module fip_div_seq
    import fip_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_overflow,
    output logic             o_div_zero
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(fip_max(WIDTH));
    localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(fip_min(WIDTH));
    localparam logic [N-1:0]     Q_LIM = N'(1) << (WIDTH - 1);
    localparam logic [N-1:0]     Q_POS = Q_LIM - N'(1);

    div_state_t       state_q, state_d;
    logic             sign_q, sign_d;
    logic             dneg_q, dneg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [N-1:0]     num_q, num_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] abs_a, abs_b, res;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic [N-1:0]     quo_neg;
    logic             ovf;

    assign abs_a   = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign abs_b   = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
    assign rem_sh  = {rem_q, num_q[N-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign quo_neg = -quo_q;
    assign res     = sign_q ? quo_neg[WIDTH-1:0] : quo_q[WIDTH-1:0];
    assign ovf     = quo_q > (sign_q ? Q_LIM : Q_POS);

    assign o_ready    = state_q == IDLE;
    assign o_valid    = state_q == DONE;
    assign o_quotient = quot_q;
    assign o_overflow = ovf_q;
    assign o_div_zero = dz_q;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dneg_d  = dneg_q;
        dvs_d   = dvs_q;
        num_d   = num_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (i_valid) begin
                state_d = CALC;
                sign_d  = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                dneg_d  = i_dividend[WIDTH-1];
                dvs_d   = abs_b;
                num_d   = N'(abs_a) << FRAC;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
            end
            CALC: if (dvs_q == '0) begin
                state_d = DONE;
                quot_d  = dneg_q ? Q_MIN : Q_MAX;
                ovf_d   = 1'b1;
                dz_d    = 1'b1;
            end else if (cnt_q == CW'(N)) begin
                state_d = DONE;
                quot_d  = (ovf && SATURATE) ? (sign_q ? Q_MIN : Q_MAX) : res;
                ovf_d   = ovf;
                dz_d    = 1'b0;
            end else begin
                rem_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                quo_d = {quo_q[N-2:0], ~rem_sub[WIDTH]};
                num_d = num_q << 1;
                cnt_d = cnt_q + CW'(1);
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dneg_q  <= 1'b0;
            dvs_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dneg_q  <= dneg_d;
            dvs_q   <= dvs_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_fip_div_seq.sv
// tb_fip_div_seq: table, corner-sequence and random checks of fip_div_seq in saturating and wrapping builds
module tb_fip_div_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        ready1, valid1, ovf1, dz1;
    logic        ready0, valid0, ovf0, dz0;
    logic [31:0] q1, q0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fip_div_seq #(.WIDTH(32), .FRAC(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(ready1),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(valid1), .i_ready(i_ready),
        .o_quotient(q1), .o_overflow(ovf1), .o_div_zero(dz1)
    );

    fip_div_seq #(.WIDTH(32), .FRAC(16), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(ready0),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(valid0), .i_ready(i_ready),
        .o_quotient(q0), .o_overflow(ovf0), .o_div_zero(dz0)
    );

    typedef struct {
        logic [31:0] a, b, q_sat, q_wrap;
        logic        ovf, dz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // plain-arithmetic reference: scale |a| by 2^16, integer divide, then apply sign and range rules
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sat,
                         output logic [31:0] q, output logic ovf, output logic dz);
        logic [31:0] na, nb;
        logic [63:0] ma, mb, qm, full;
        logic        neg;
        na = -a;
        nb = -b;
        ma = {32'd0, a[31] ? na : a};
        mb = {32'd0, b[31] ? nb : b};
        if (mb == 0) begin
            dz  = 1'b1;
            ovf = 1'b1;
            q   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            dz   = 1'b0;
            neg  = a[31] ^ b[31];
            qm   = (ma * 64'd65536) / mb;
            ovf  = neg ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF);
            full = neg ? -qm : qm;
            q    = (ovf && sat) ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : full[31:0];
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq1, input logic [31:0] eq0, input logic eovf,
                         input logic edz, input int hold);
        int lat;
        logic [31:0] s1, s0;
        logic so, sd;
        @(negedge clk);
        chk({name, ".ready"}, 64'(ready1), 64'd1);
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        @(posedge clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        lat = 0;
        while (!valid1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd49);
        chk({name, ".valid_wrap"}, 64'(valid0), 64'd1);
        chk({name, ".q_sat"}, 64'(q1), 64'(eq1));
        chk({name, ".q_wrap"}, 64'(q0), 64'(eq0));
        chk({name, ".flags_sat"}, {62'd0, ovf1, dz1}, {62'd0, eovf, edz});
        chk({name, ".flags_wrap"}, {62'd0, ovf0, dz0}, {62'd0, eovf, edz});
        s1 = q1; s0 = q0; so = ovf1; sd = dz1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, ".hold_state"}, {62'd0, valid1, ready1}, 64'b10);
            chk({name, ".hold_out"}, {q1, q0}, {s1, s0});
            chk({name, ".hold_flags"}, {62'd0, ovf1, dz1}, {62'd0, so, sd});
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk({name, ".release"}, {62'd0, valid1, ready1}, 64'b01);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] a, b, e1, e0;
        logic eo, ed, eo0, ed0;
        int r;
        vecs = '{
            '{32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0},
            '{32'h0000_8000, 32'h0000_4000, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0},
            '{32'h0000_0002, 32'h0000_0003, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0, 1'b0},
            '{32'hFFFF_0000, 32'h0000_8000, 32'hFFFE_0000, 32'hFFFE_0000, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0},
            '{32'h7FFF_FFFF, 32'h0000_4000, 32'h7FFF_FFFF, 32'hFFFF_FFFC, 1'b1, 1'b0},
            '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1},
            '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1},
            '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0},
            '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0},
            '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1'b0}
        };
        #3 reset_n = 1'b0;
        #2;
        chk("reset.ready", 64'(ready1), 64'd1);
        chk("reset.valid", 64'(valid1), 64'd0);
        chk("reset.q", {q1, q0}, 64'd0);
        chk("reset.flags", {60'd0, ovf1, dz1, ovf0, dz0}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q_sat, vecs[i].q_wrap,
                  vecs[i].ovf, vecs[i].dz, 0);

        do_op("backpressure", 32'h0003_0000, 32'hFFFE_0000, 32'hFFFE_8000, 32'hFFFE_8000,
              1'b0, 1'b0, 10);

        @(negedge clk);
        i_dividend = 32'h0001_0000;
        i_divisor  = 32'h0000_4000;
        i_valid    = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset.state", {60'd0, valid1, ready1, valid0, ready0}, 64'b0101);
        chk("midreset.q", {q1, q0}, 64'd0);
        chk("midreset.flags", {60'd0, ovf1, dz1, ovf0, dz0}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op("after_reset", 32'h0001_0000, 32'h0000_4000, 32'h0004_0000, 32'h0004_0000,
              1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            a = (r[0]) ? $urandom : {{16{r[1]}}, 16'($urandom)};
            b = (r == 0) ? 32'd0 : (r < 4) ? 32'($signed(32'($urandom_range(0, 511))) - 256)
                                          : (r < 7) ? {{12{r[1]}}, 20'($urandom)} : $urandom;
            model(a, b, 1'b1, e1, eo, ed);
            model(a, b, 1'b0, e0, eo0, ed0);
            do_op($sformatf("rand%0d", n), a, b, e1, e0, eo, ed, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
